// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth step: window codes, decoded
// operation type and default operand widths.
package booth_pkg;

  localparam int MW_DEF = 8;
  localparam int AW_DEF = 16;

  // Booth window codes {b(2i+1), b(2i), b(2i-1)}; zero and +/-M each have two encodings.
  localparam logic [2:0] ZERO_A    = 3'b000;
  localparam logic [2:0] ZERO_B    = 3'b111;
  localparam logic [2:0] PLUS_M_A  = 3'b001;
  localparam logic [2:0] PLUS_M_B  = 3'b010;
  localparam logic [2:0] PLUS_2M   = 3'b011;
  localparam logic [2:0] MINUS_2M  = 3'b100;
  localparam logic [2:0] MINUS_M_A = 3'b101;
  localparam logic [2:0] MINUS_M_B = 3'b110;

  typedef enum logic [2:0] {
    op_zero,
    op_pos1,
    op_pos2,
    op_neg1,
    op_neg2
  } op_t;

  function automatic op_t decode_op(input logic [2:0] window);
    op_t op;
    op = op_zero;
    case (window)
      ZERO_A, ZERO_B:         op = op_zero;
      PLUS_M_A, PLUS_M_B:     op = op_pos1;
      PLUS_2M:                op = op_pos2;
      MINUS_2M:               op = op_neg2;
      MINUS_M_A, MINUS_M_B:   op = op_neg1;
      default:                op = op_zero;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: decodes the window and
// produces the AW-bit sign-extended partial product {0, +/-M, +/-2M}.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [2:0]    mult_1,
  input  logic [MW-1:0] mult_2,
  output logic [AW-1:0] pp
);

  op_t           op;
  logic [AW-1:0] m_ext;
  logic [AW-1:0] mag;

  assign op    = decode_op(mult_1);
  assign m_ext = {{(AW-MW){mult_2[MW-1]}}, mult_2};

  // Negating after widening to AW bits keeps -(-2^(MW-1)) exact.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mag = '0;
    pp  = '0;
    case (op)
      op_pos1, op_neg1: mag = m_ext;
      op_pos2, op_neg2: mag = m_ext << 1;
      default:          mag = '0;
    endcase
    if (op == op_neg1 || op == op_neg2) pp = ~mag + AW'(1);
    else                                pp = mag;
  end

endmodule

// File: rtl/booth_step.sv
// One registered radix-4 Booth step: mult_next <= mult_pre + PP(window, M),
// with a ready flag that mirrors the enable one cycle later.
module booth_step
  import booth_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [2:0]    mult_1,
  input  logic [MW-1:0] mult_2,
  input  logic [AW-1:0] mult_pre,
  output logic [AW-1:0] mult_next,
  output logic          rdy
);

  logic [AW-1:0] pp;
  logic [AW-1:0] mult_next_d, mult_next_q;
  logic          rdy_d, rdy_q;

  booth_pp_gen #(
    .MW (MW),
    .AW (AW)
  ) u_pp_gen (
    .mult_1 (mult_1),
    .mult_2 (mult_2),
    .pp     (pp)
  );

  // Sum wraps modulo 2^AW; the carry-out is intentionally dropped.
  always_comb begin
    mult_next_d = mult_next_q;
    rdy_d       = en;
    if (en) mult_next_d = mult_pre + pp;
  end

  // rst_n is an active-high synchronous reset despite its name.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst_n) begin
      mult_next_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      mult_next_q <= mult_next_d;
      rdy_q       <= rdy_d;
    end
  end

  assign mult_next = mult_next_q;
  assign rdy       = rdy_q;

endmodule

// File: tb/tb_booth_step.sv
// Scoreboard bench for booth_step: the driver queues hand-computed expected
// outputs per edge, and a monitor compares them just after each rising edge.
module tb_booth_step;

  localparam int MW = 8;
  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    mult_1;
  logic [MW-1:0] mult_2;
  logic [AW-1:0] mult_pre;
  logic [AW-1:0] mult_next;
  logic          rdy;

  typedef struct {
    logic          exp_rdy;
    logic [AW-1:0] exp_val;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  booth_step #(
    .MW (MW),
    .AW (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mult_1    (mult_1),
    .mult_2    (mult_2),
    .mult_pre  (mult_pre),
    .mult_next (mult_next),
    .rdy       (rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  // Apply one cycle of stimulus and queue what the outputs must be after the next edge.
  task automatic drive(input bit rst, input bit e, input logic [2:0] w,
                       input logic [MW-1:0] m, input logic [AW-1:0] pre,
                       input bit er, input logic [AW-1:0] ev, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n    = rst;
    en       = e;
    mult_1   = w;
    mult_2   = m;
    mult_pre = pre;
    x.exp_rdy = er;
    x.exp_val = ev;
    x.name    = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check({x.name, "_rdy"}, 32'(rdy), 32'(x.exp_rdy));
        check({x.name, "_val"}, 32'(mult_next), 32'(x.exp_val));
      end else if (rdy === 1'b1) begin
        check("unexpected_rdy", 32'(rdy), 32'd0);
      end
    end
  end

  initial begin
    logic [2:0]    win [8];
    logic [AW-1:0] sweep_exp [8];
    logic [MW-1:0] m_neg63;

    rst_n = 1'b1; en = 1'b0; mult_1 = '0; mult_2 = '0; mult_pre = '0;
    m_neg63 = 8'hC1;
    sweep_exp = '{16'h0014, 16'hFFD5, 16'hFFD5, 16'hFF96,
                  16'h0092, 16'h0053, 16'h0053, 16'h0014};

    // Reset with en=1 must still clear.
    drive(1, 1, 3'b001, 8'h05, 16'h1234, 0, 16'h0000, "reset");

    // Window sweep, M=-63, pre=20; each window held two cycles.
    for (int i = 0; i < 8; i++) begin
      win[i] = 3'(i);
      drive(0, 1, win[i], m_neg63, 16'd20, 1, sweep_exp[i], $sformatf("sweep%0d_a", i));
      drive(0, 1, win[i], m_neg63, 16'd20, 1, sweep_exp[i], $sformatf("sweep%0d_b", i));
    end

    // Most negative multiplicand.
    drive(0, 1, 3'b100, 8'h80, 16'h0000, 1, 16'h0100, "mmin_neg2m");
    drive(0, 1, 3'b011, 8'h80, 16'h0000, 1, 16'hFF00, "mmin_pos2m");
    drive(0, 1, 3'b101, 8'h80, 16'h0000, 1, 16'h0080, "mmin_negm");

    // Modulo wrap, no saturation.
    drive(0, 1, 3'b001, 8'h01, 16'h7FFF, 1, 16'h8000, "wrap");

    // Enable gating: isolated single-cycle rdy pulse, value held while en=0.
    drive(0, 0, 3'b011, 8'h22, 16'h0001, 0, 16'h8000, "gate_idle");
    drive(0, 1, 3'b001, 8'h05, 16'd100,  1, 16'd105,  "gate_step");
    drive(0, 0, 3'b011, 8'h7F, 16'h4444, 0, 16'd105,  "gate_hold0");
    drive(0, 0, 3'b100, 8'h80, 16'hFFFF, 0, 16'd105,  "gate_hold1");
    drive(0, 0, 3'b101, 8'h33, 16'h0000, 0, 16'd105,  "gate_hold2");

    // Mid-stream reset while stepping, then resume.
    drive(0, 1, 3'b010, 8'h10, 16'h0100, 1, 16'h0110, "ms_step0");
    drive(0, 1, 3'b110, 8'h10, 16'h0100, 1, 16'h00F0, "ms_step1");
    drive(1, 1, 3'b011, 8'h10, 16'h0100, 0, 16'h0000, "ms_reset");
    drive(0, 1, 3'b011, 8'h10, 16'h0100, 1, 16'h0120, "ms_resume0");
    drive(0, 1, 3'b100, 8'hFF, 16'h0000, 1, 16'h0002, "ms_resume1");

    drive(0, 0, 3'b000, 8'h00, 16'h0000, 0, 16'h0002, "final_idle");

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
